// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller signal bundle between pipeline datapath and sequencer.
// master = pipeline side, slave = pipe_hazard_ctrl.
interface pipe_hazard_ctrl_if;
  logic       if_req;
  logic       if_ack;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_rs1_used;
  logic       id_rs2_used;
  logic       ex_is_load;
  logic [4:0] ex_rd;
  logic       ex_mdu_req;
  logic       ex_mdu_div;
  logic       mem_req;
  logic       mem_ack;
  logic       mem_trap_req;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       stall_mem;
  logic       trap;
  logic       mdu_done;
  logic       mem_bus_err;
  logic       if_drop;

  modport master (
    output if_req, if_ack,
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    output ex_is_load, ex_rd, ex_mdu_req, ex_mdu_div,
    output mem_req, mem_ack, mem_trap_req,
    input  stall_if, stall_id, stall_ex, stall_mem,
    input  trap, mdu_done, mem_bus_err, if_drop
  );

  modport slave (
    input  if_req, if_ack,
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
    input  ex_is_load, ex_rd, ex_mdu_req, ex_mdu_div,
    input  mem_req, mem_ack, mem_trap_req,
    output stall_if, stall_id, stall_ex, stall_mem,
    output trap, mdu_done, mem_bus_err, if_drop
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: MDU latency, data-bus
// waits with timeout, load-use interlock and trap flush with fetch discard.
module pipe_hazard_ctrl #(
  parameter int unsigned MUL_LAT     = 2,
  parameter int unsigned DIV_LAT     = 33,
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave hz
);

  localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned CW = $clog2(MAX_LAT + 1);
  localparam int unsigned TW = $clog2(BUS_TIMEOUT + 1);
  localparam logic [CW-1:0] MUL_M1 = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV_LAT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(BUS_TIMEOUT);

  typedef enum logic [1:0] {
    M_IDLE,
    M_BUSY,
    M_DONE
  } mdu_st_e;

  typedef enum logic {
    B_IDLE,
    B_WAIT
  } bus_st_e;

  mdu_st_e       mdu_st_q, mdu_st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  bus_st_e       bus_st_q, bus_st_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          flag_q, flag_d;

  logic          mdu_busy;
  logic          mdu_done;
  logic          mem_bus_err;
  logic          mem_wait;
  logic          load_use;
  logic          trap;
  logic [CW-1:0] lat_m1;
  logic          rs1_hit;
  logic          rs2_hit;

  assign lat_m1 = hz.ex_mdu_div ? DIV_M1 : MUL_M1;

  assign mem_wait = hz.mem_req & ~hz.mem_ack & ~mem_bus_err;
  assign trap     = hz.mem_trap_req & ~mem_wait;

  assign rs1_hit  = hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd);
  assign rs2_hit  = hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd);
  assign load_use = hz.ex_is_load & (hz.ex_rd != 5'd0)
                  & (rs1_hit | rs2_hit);

  // MDU sequencer; leaving M_DONE only needs MEM to accept (mdu_busy=0 there)
  always_comb begin
    mdu_st_d = mdu_st_q;
    cnt_d    = cnt_q;
    mdu_busy = 1'b0;
    mdu_done = 1'b0;
    unique case (mdu_st_q)
      M_IDLE: begin
        if (hz.ex_mdu_req) begin
          mdu_busy = 1'b1;
          cnt_d    = lat_m1;
          mdu_st_d = (lat_m1 == '0) ? M_DONE : M_BUSY;
        end
      end
      M_BUSY: begin
        mdu_busy = 1'b1;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) mdu_st_d = M_DONE;
      end
      M_DONE: begin
        mdu_done = 1'b1;
        if (!mem_wait) mdu_st_d = M_IDLE;
      end
      default: mdu_st_d = M_IDLE;
    endcase
    if (trap) begin
      mdu_st_d = M_IDLE;
      cnt_d    = '0;
    end
  end

  always_comb begin
    bus_st_d    = bus_st_q;
    tcnt_d      = tcnt_q;
    mem_bus_err = 1'b0;
    unique case (bus_st_q)
      B_IDLE: begin
        if (hz.mem_req && !hz.mem_ack) begin
          bus_st_d = B_WAIT;
          tcnt_d   = TW'(1);
        end
      end
      B_WAIT: begin
        if (hz.mem_ack || !hz.mem_req) begin
          bus_st_d = B_IDLE;
          tcnt_d   = '0;
        end else if (tcnt_q == T_MAX) begin
          mem_bus_err = 1'b1;
          bus_st_d    = B_IDLE;
          tcnt_d      = '0;
        end else begin
          tcnt_d = tcnt_q + TW'(1);
        end
      end
      default: bus_st_d = B_IDLE;
    endcase
  end

  // A fetch still outstanding at trap time returns stale data later
  always_comb begin
    flag_d = flag_q;
    if (trap && hz.if_req && !hz.if_ack) flag_d = 1'b1;
    else if (hz.if_ack)                  flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_st_q <= M_IDLE;
      cnt_q    <= '0;
      bus_st_q <= B_IDLE;
      tcnt_q   <= '0;
      flag_q   <= 1'b0;
    end else begin
      mdu_st_q <= mdu_st_d;
      cnt_q    <= cnt_d;
      bus_st_q <= bus_st_d;
      tcnt_q   <= tcnt_d;
      flag_q   <= flag_d;
    end
  end

  assign hz.stall_mem = ~trap & mem_wait;
  assign hz.stall_ex  = hz.stall_mem | (~trap & mdu_busy);
  assign hz.stall_id  = hz.stall_ex | (~trap & load_use);
  assign hz.stall_if  = hz.stall_id
                      | (~trap & ((hz.if_req & ~hz.if_ack) | flag_q));
  assign hz.trap        = trap;
  assign hz.mdu_done    = mdu_done;
  assign hz.mem_bus_err = mem_bus_err;
  assign hz.if_drop     = flag_q & hz.if_ack;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: a cycle-level reference model
// queues expected outputs, a negedge monitor pops and compares them.
module tb_pipe_hazard_ctrl;

  localparam int MUL_LAT = 2;
  localparam int DIV_LAT = 33;
  localparam int BUS_TO  = 8;

  logic clk;
  logic rst;

  pipe_hazard_ctrl_if hz ();

  pipe_hazard_ctrl #(
    .MUL_LAT    (MUL_LAT),
    .DIV_LAT    (DIV_LAT),
    .BUS_TIMEOUT(BUS_TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic s_if;
    logic s_id;
    logic s_ex;
    logic s_mem;
    logic trap;
    logic done;
    logic err;
    logic drop;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Model state: busy cycles still owed, result waiting in EX,
  // consecutive unacked bus cycles, stale fetch pending
  int m_left;
  bit m_done;
  int b_wait;
  bit f_drop;

  task automatic chk(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("stall_if",    hz.stall_if,    e.s_if);
      chk("stall_id",    hz.stall_id,    e.s_id);
      chk("stall_ex",    hz.stall_ex,    e.s_ex);
      chk("stall_mem",   hz.stall_mem,   e.s_mem);
      chk("trap",        hz.trap,        e.trap);
      chk("mdu_done",    hz.mdu_done,    e.done);
      chk("mem_bus_err", hz.mem_bus_err, e.err);
      chk("if_drop",     hz.if_drop,     e.drop);
    end
  end

  task automatic clr();
    hz.if_req       = 1'b0;
    hz.if_ack       = 1'b0;
    hz.id_rs1       = 5'd0;
    hz.id_rs2       = 5'd0;
    hz.id_rs1_used  = 1'b0;
    hz.id_rs2_used  = 1'b0;
    hz.ex_is_load   = 1'b0;
    hz.ex_rd        = 5'd0;
    hz.ex_mdu_req   = 1'b0;
    hz.ex_mdu_div   = 1'b0;
    hz.mem_req      = 1'b0;
    hz.mem_ack      = 1'b0;
    hz.mem_trap_req = 1'b0;
  endtask

  // Predict this cycle from current inputs, then advance across the edge
  task automatic tick();
    exp_t e;
    bit   start, busy, err, wt, lu, trp;
    int   lat;
    start = (m_left == 0) && !m_done && hz.ex_mdu_req;
    lat   = hz.ex_mdu_div ? DIV_LAT : MUL_LAT;
    busy  = start || (m_left > 0);
    err   = hz.mem_req && !hz.mem_ack && (b_wait == BUS_TO);
    wt    = hz.mem_req && !hz.mem_ack && !err;
    lu    = hz.ex_is_load && (hz.ex_rd != 0) &&
            ((hz.id_rs1_used && hz.id_rs1 == hz.ex_rd) ||
             (hz.id_rs2_used && hz.id_rs2 == hz.ex_rd));
    trp   = hz.mem_trap_req && !wt;
    if (!rst) begin
      e.s_mem = !trp && wt;
      e.s_ex  = !trp && (wt || busy);
      e.s_id  = !trp && (wt || busy || lu);
      e.s_if  = !trp && (wt || busy || lu || f_drop ||
                         (hz.if_req && !hz.if_ack));
      e.trap  = trp;
      e.done  = m_done;
      e.err   = err;
      e.drop  = f_drop && hz.if_ack;
      exp_q.push_back(e);
    end
    @(posedge clk);
    if (rst) begin
      m_left = 0;
      m_done = 0;
      b_wait = 0;
      f_drop = 0;
    end else begin
      if (trp) begin
        m_left = 0;
        m_done = 0;
      end else begin
        if (start) m_left = lat;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1;
        end else if (m_done && !wt) begin
          m_done = 0;
        end
      end
      b_wait = wt ? b_wait + 1 : 0;
      if (trp && hz.if_req && !hz.if_ack) f_drop = 1;
      else if (hz.if_ack)                 f_drop = 0;
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int ack_div;
    clr();
    rst = 1'b1;
    m_left = 0; m_done = 0; b_wait = 0; f_drop = 0;
    ticks(2);
    rst = 1'b0;
    tick();

    // reset in the middle of a divide
    hz.ex_mdu_req = 1'b1; hz.ex_mdu_div = 1'b1;
    ticks(4);
    rst = 1'b1;
    ticks(3);
    rst = 1'b0;
    clr();
    ticks(2);

    // multiply, result held one cycle with request still up
    hz.ex_mdu_req = 1'b1;
    ticks(3);
    clr();
    ticks(2);

    // load-use on rs2, then the x0 exemption
    hz.ex_is_load = 1'b1; hz.ex_rd = 5'd5;
    hz.id_rs2 = 5'd5; hz.id_rs2_used = 1'b1;
    tick();
    hz.ex_rd = 5'd0; hz.id_rs2 = 5'd0;
    tick();
    clr();

    // bus wait of 4 cycles, then a full timeout
    hz.mem_req = 1'b1;
    ticks(4);
    hz.mem_ack = 1'b1;
    tick();
    clr();
    hz.mem_req = 1'b1;
    ticks(BUS_TO + 1);
    clr();
    tick();

    // trap during divide with a fetch in flight
    hz.ex_mdu_req = 1'b1; hz.ex_mdu_div = 1'b1;
    ticks(2);
    hz.if_req = 1'b1; hz.mem_trap_req = 1'b1;
    tick();
    hz.mem_trap_req = 1'b0; hz.ex_mdu_req = 1'b0;
    ticks(2);
    hz.if_ack = 1'b1;
    tick();
    clr();
    tick();

    // trap parked behind a bus wait
    hz.mem_req = 1'b1; hz.mem_trap_req = 1'b1;
    ticks(3);
    hz.mem_ack = 1'b1;
    tick();
    clr();

    // trap together with a bus timeout
    hz.mem_req = 1'b1; hz.mem_trap_req = 1'b1;
    ticks(BUS_TO + 1);
    clr();
    tick();

    // trap in the same cycle as the fetch returns
    hz.if_req = 1'b1; hz.if_ack = 1'b1; hz.mem_trap_req = 1'b1;
    tick();
    hz.if_ack = 1'b0; hz.mem_trap_req = 1'b0;
    tick();
    clr();
    tick();

    // randomized phases with decreasing bus-ack probability
    for (int p = 0; p < 4; p++) begin
      ack_div = (p == 0) ? 1 : (p == 1) ? 4 : (p == 2) ? 8 : 12;
      for (int i = 0; i < 600; i++) begin
        rst = ($urandom_range(0, 299) == 0);
        hz.if_req       = ($urandom_range(0, 3) != 0);
        hz.if_ack       = hz.if_req && ($urandom_range(0, 2) == 0);
        hz.id_rs1       = 5'($urandom_range(0, 7));
        hz.id_rs2       = 5'($urandom_range(0, 7));
        hz.id_rs1_used  = 1'($urandom_range(0, 1));
        hz.id_rs2_used  = 1'($urandom_range(0, 1));
        hz.ex_is_load   = ($urandom_range(0, 3) == 0);
        hz.ex_rd        = 5'($urandom_range(0, 7));
        hz.ex_mdu_req   = ($urandom_range(0, 5) == 0);
        hz.ex_mdu_div   = ($urandom_range(0, 3) == 0);
        if (!(hz.mem_req && !hz.mem_ack))
          hz.mem_req    = ($urandom_range(0, 2) == 0);
        hz.mem_ack      = hz.mem_req && ($urandom_range(0, ack_div) == 0);
        hz.mem_trap_req = ($urandom_range(0, 19) == 0);
        tick();
      end
    end
    rst = 1'b0;
    clr();
    ticks(2);

    @(negedge clk);
    #1;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
